me_search_ctrl: RTL and testbench



---
 rtl/me_search_ctrl.sv | 142 ++++++++++++++
 tb/tb_me_search_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/me_search_ctrl.sv
// Motion-estimation block sequencer: primes the SAD pipeline, tracks the minimum over all batches, emits best SAD/MV.
// Latency: start to first result is PIPE_LAT+NUM_BATCHES+1 cycles; block period is the same with ready held high.
// Backpressure: result holds in EMIT while mv_ready_i is low; the datapath is not resampled during a stall.
module me_search_ctrl #(
    parameter int SAD_BIT_WIDTH   = 14,
    parameter int NUM_BATCHES     = 16,
    parameter int BATCH_W         = 4,
    parameter int PIPE_LAT        = 6,
    parameter int BLOCKS_PER_LINE = 482
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     start_i,
    input  logic                     abort_i,
    input  logic [SAD_BIT_WIDTH-1:0] msad_i,
    input  logic [3:0]               msad_idx_i,
    input  logic                     mv_ready_i,
    output logic                     cur_read_start_o,
    output logic                     cur_next_block_o,
    output logic                     mv_valid_o,
    output logic [3:0]               mv_x_o,
    output logic [BATCH_W-1:0]       mv_y_o,
    output logic [SAD_BIT_WIDTH-1:0] best_sad_o,
    output logic                     busy_o,
    output logic                     line_done_o
);

    localparam int BLK_W = $clog2(BLOCKS_PER_LINE + 1);
    localparam int PRM_W = $clog2(PIPE_LAT + 1);
    localparam logic [PRM_W-1:0]   PRIME_LAST = PRM_W'(PIPE_LAT - 1);
    localparam logic [BATCH_W-1:0] BATCH_LAST = BATCH_W'(NUM_BATCHES - 1);
    localparam logic [BLK_W-1:0]   BLOCK_LAST = BLK_W'(BLOCKS_PER_LINE - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PRIME  = 2'd1,
        S_SEARCH = 2'd2,
        S_EMIT   = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [PRM_W-1:0]         r_prime_cnt;
    logic [BATCH_W-1:0]       r_batch_cnt;
    logic [BLK_W-1:0]         r_block_cnt;
    logic [SAD_BIT_WIDTH-1:0] r_best_sad;
    logic [3:0]               r_best_x;
    logic [BATCH_W-1:0]       r_best_y;
    logic                     r_line_done;

    logic w_handshake;
    logic w_line_end;
    logic w_take;

    assign w_handshake = (r_state == S_EMIT) && mv_ready_i;
    assign w_line_end  = w_handshake && (r_block_cnt == BLOCK_LAST);
    // First batch always loads so an all-ones SAD still yields a real candidate.
    assign w_take      = (r_batch_cnt == '0) || (msad_i < r_best_sad);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start_i) w_state_nxt = S_PRIME;
            S_PRIME:  if (r_prime_cnt == PRIME_LAST) w_state_nxt = S_SEARCH;
            S_SEARCH: if (r_batch_cnt == BATCH_LAST) w_state_nxt = S_EMIT;
            S_EMIT:   if (mv_ready_i) w_state_nxt = w_line_end ? S_IDLE : S_PRIME;
            default:  w_state_nxt = S_IDLE;
        endcase
        if (abort_i) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_prime_cnt <= '0;
            r_batch_cnt <= '0;
            r_block_cnt <= '0;
            r_best_sad  <= '1;
            r_best_x    <= '0;
            r_best_y    <= '0;
            r_line_done <= 1'b0;
        end else if (abort_i) begin
            r_prime_cnt <= '0;
            r_batch_cnt <= '0;
            r_block_cnt <= '0;
            r_best_sad  <= '1;
            r_line_done <= 1'b0;
        end else begin
            r_line_done <= w_line_end;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_prime_cnt <= '0;
                        r_block_cnt <= '0;
                    end
                end
                S_PRIME: begin
                    if (r_prime_cnt == PRIME_LAST) begin
                        r_prime_cnt <= '0;
                        r_batch_cnt <= '0;
                        r_best_sad  <= '1;
                    end else begin
                        r_prime_cnt <= r_prime_cnt + 1'b1;
                    end
                end
                S_SEARCH: begin
                    if (w_take) begin
                        r_best_sad <= msad_i;
                        r_best_x   <= msad_idx_i;
                        r_best_y   <= r_batch_cnt;
                    end
                    r_batch_cnt <= r_batch_cnt + 1'b1;
                end
                S_EMIT: begin
                    if (w_handshake && !w_line_end) begin
                        r_block_cnt <= r_block_cnt + 1'b1;
                        r_prime_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Result fields read as zero outside EMIT so reset and idle present a clean bus.
    assign cur_read_start_o = (r_state == S_PRIME) && (r_prime_cnt == '0);
    assign cur_next_block_o = (r_state == S_SEARCH) && (r_batch_cnt == BATCH_LAST);
    assign mv_valid_o       = (r_state == S_EMIT);
    assign mv_x_o           = mv_valid_o ? r_best_x   : '0;
    assign mv_y_o           = mv_valid_o ? r_best_y   : '0;
    assign best_sad_o       = mv_valid_o ? r_best_sad : '0;
    assign busy_o           = (r_state != S_IDLE);
    assign line_done_o      = r_line_done;

endmodule

// File: tb/tb_me_search_ctrl.sv
module tb_me_search_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        start_i;
    logic        abort_i;
    logic [13:0] msad_i;
    logic [3:0]  msad_idx_i;
    logic        mv_ready_i;
    logic        cur_read_start_o;
    logic        cur_next_block_o;
    logic        mv_valid_o;
    logic [3:0]  mv_x_o;
    logic [3:0]  mv_y_o;
    logic [13:0] best_sad_o;
    logic        busy_o;
    logic        line_done_o;

    int checks = 0;
    int errors = 0;

    logic [13:0] pv [16];
    logic [3:0]  pi [16];

    me_search_ctrl #(
        .SAD_BIT_WIDTH  (14),
        .NUM_BATCHES    (16),
        .BATCH_W        (4),
        .PIPE_LAT       (6),
        .BLOCKS_PER_LINE(2)
    ) dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .start_i         (start_i),
        .abort_i         (abort_i),
        .msad_i          (msad_i),
        .msad_idx_i      (msad_idx_i),
        .mv_ready_i      (mv_ready_i),
        .cur_read_start_o(cur_read_start_o),
        .cur_next_block_o(cur_next_block_o),
        .mv_valid_o      (mv_valid_o),
        .mv_x_o          (mv_x_o),
        .mv_y_o          (mv_y_o),
        .best_sad_o      (best_sad_o),
        .busy_o          (busy_o),
        .line_done_o     (line_done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic fill(input logic [13:0] val, input int mul);
        for (int b = 0; b < 16; b++) begin
            pv[b] = val;
            pi[b] = 4'((b * mul) & 15);
        end
    endtask

    task automatic do_start();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    // Entered in the cycle where cur_read_start_o should be high; leaves in the last EMIT cycle with ready high.
    task automatic run_block(input string name, input int stall,
                             input logic [3:0] ex, input logic [3:0] ey, input logic [13:0] es);
        checks++;
        if (cur_read_start_o !== 1'b1 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL %s start: read_start=%b busy=%b, want 1 1", name, cur_read_start_o, busy_o);
        end
        for (int p = 1; p <= 21; p++) begin
            step();
            if (p >= 6) begin
                msad_i     = pv[p-6];
                msad_idx_i = pi[p-6];
            end else begin
                msad_i     = '0;
                msad_idx_i = '0;
            end
            if (p == 1) begin
                checks++;
                if (cur_read_start_o !== 1'b0) begin
                    errors++;
                    $display("FAIL %s read_start_len: got %b want 0", name, cur_read_start_o);
                end
            end
            if (p == 20 || p == 21) begin
                checks++;
                if (cur_next_block_o !== (p == 21) || mv_valid_o !== 1'b0) begin
                    errors++;
                    $display("FAIL %s next_block p=%0d: next=%b valid=%b want %b 0",
                             name, p, cur_next_block_o, mv_valid_o, p == 21);
                end
            end
        end
        step();
        msad_i     = '0;
        msad_idx_i = '0;
        mv_ready_i = (stall == 0);
        for (int s = 0; s <= stall; s++) begin
            if (s > 0) begin
                step();
                if (s == stall) mv_ready_i = 1'b1;
            end
            checks++;
            if (mv_valid_o !== 1'b1 || mv_x_o !== ex || mv_y_o !== ey || best_sad_o !== es || line_done_o !== 1'b0) begin
                errors++;
                $display("FAIL %s emit s=%0d: valid=%b x=%0d y=%0d sad=%0d ld=%b want 1 %0d %0d %0d 0",
                         name, s, mv_valid_o, mv_x_o, mv_y_o, best_sad_o, line_done_o, ex, ey, es);
            end
        end
    endtask

    task automatic check_line_done(input string name);
        step();
        checks++;
        if (line_done_o !== 1'b1 || busy_o !== 1'b0 || mv_valid_o !== 1'b0 || cur_read_start_o !== 1'b0) begin
            errors++;
            $display("FAIL %s line_done: ld=%b busy=%b valid=%b rs=%b want 1 0 0 0",
                     name, line_done_o, busy_o, mv_valid_o, cur_read_start_o);
        end
        step();
        checks++;
        if (line_done_o !== 1'b0) begin
            errors++;
            $display("FAIL %s line_done_pulse: got %b want 0", name, line_done_o);
        end
    endtask

    task automatic test_reset();
        rst_n_i    = 1'b0;
        start_i    = 1'b0;
        abort_i    = 1'b0;
        msad_i     = '0;
        msad_idx_i = '0;
        mv_ready_i = 1'b1;
        #12;
        checks++;
        if ({cur_read_start_o, cur_next_block_o, mv_valid_o, mv_x_o, mv_y_o, best_sad_o, busy_o, line_done_o} !== 27'd0) begin
            errors++;
            $display("FAIL reset_outputs: rs=%b nb=%b v=%b x=%0d y=%0d sad=%0d busy=%b ld=%b want all 0",
                     cur_read_start_o, cur_next_block_o, mv_valid_o, mv_x_o, mv_y_o, best_sad_o, busy_o, line_done_o);
        end
        step();
        rst_n_i = 1'b1;
        step();
        step();
        checks++;
        if (busy_o !== 1'b0 || mv_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b valid=%b want 0 0", busy_o, mv_valid_o);
        end
    endtask

    task automatic test_basic_line();
        fill(14'd100, 7);
        pi[5] = 4'd9;
        pv[5] = 14'd20;
        do_start();
        run_block("basic", 0, 4'd9, 4'd5, 14'd20);
        fill(14'd50, 5);
        pv[3] = 14'd10; pi[3] = 4'd2;
        pv[7] = 14'd10; pi[7] = 4'd1;
        step();
        run_block("tie", 0, 4'd2, 4'd3, 14'd10);
        check_line_done("basic");
    endtask

    task automatic test_stall_all_ones();
        for (int b = 0; b < 16; b++) begin
            pv[b] = 14'(200 - b);
            pi[b] = 4'((b + 4) & 15);
        end
        do_start();
        run_block("stall", 5, 4'd3, 4'd15, 14'd185);
        fill(14'd16383, 3);
        pi[0] = 4'd11;
        step();
        run_block("all_ones", 0, 4'd11, 4'd0, 14'd16383);
        check_line_done("all_ones");
    endtask

    task automatic test_abort();
        int bad;
        bad = 0;
        fill(14'd100, 1);
        do_start();
        for (int p = 1; p <= 3; p++) step();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        checks++;
        if (cur_read_start_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL abort_busy_start: rs=%b busy=%b want 0 1", cur_read_start_o, busy_o);
        end
        for (int p = 5; p <= 10; p++) step();
        msad_i  = 14'd5;
        abort_i = 1'b1;
        start_i = 1'b1;
        step();
        abort_i = 1'b0;
        start_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || mv_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: busy=%b valid=%b want 0 0", busy_o, mv_valid_o);
        end
        for (int c = 0; c < 30; c++) begin
            step();
            if (mv_valid_o || line_done_o || busy_o || cur_read_start_o) bad++;
        end
        msad_i = '0;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL abort_quiet: %0d active cycles, want 0", bad);
        end
    endtask

    task automatic test_reset_mid_prime();
        fill(14'd100, 7);
        do_start();
        #2;
        rst_n_i = 1'b0;
        #1;
        checks++;
        if (cur_read_start_o !== 1'b0 || busy_o !== 1'b0 || mv_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: rs=%b busy=%b valid=%b want 0 0 0", cur_read_start_o, busy_o, mv_valid_o);
        end
        step();
        step();
        rst_n_i = 1'b1;
        step();
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_restart: busy=%b want 0", busy_o);
        end
        pv[12] = 14'd1;
        pi[12] = 4'd14;
        do_start();
        run_block("restart0", 0, 4'd14, 4'd12, 14'd1);
        fill(14'd77, 1);
        pv[0] = 14'd76;
        step();
        run_block("restart1", 0, 4'd0, 4'd0, 14'd76);
        check_line_done("restart");
    endtask

    initial begin
        test_reset();
        test_basic_line();
        test_stall_all_ones();
        test_abort();
        test_reset_mid_prime();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
